// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, tap mask and the predictor step.
package prbs_pkg;

  localparam int unsigned PRBS_W = 32;
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 32'hEA00_0001;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Shift left, feeding back the parity of the tapped bits (31,30,29,27,25,0).
  function automatic logic [PRBS_W-1:0] prbs_step(input logic [PRBS_W-1:0] p);
    return {p[PRBS_W-2:0], ^(p & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS31-style word checker: hunts for a seed, verifies LOCK_CNT consecutive
// predictions, then free-runs the predictor and counts errors while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PRBS_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic              lost_lock,
  output logic [31:0]       err_count,
  output logic [31:0]       word_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);
  localparam bit          SEED_LOCKS = (LOCK_CNT <= 1);

  state_e              state;
  logic [PRBS_W-1:0]   pred;
  logic [MATCH_W-1:0]  match_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic                hit_c;
  logic                word_inc_c;
  logic                err_inc_c;

  assign hit_c      = (data_in == pred);
  assign word_inc_c = data_valid && (state == LOCKED);
  assign err_inc_c  = word_inc_c && !hit_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lost_lock <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      lost_lock <= 1'b0;
      if (data_valid) begin
        if (state == LOCKED) begin
          // Free-running prediction: never reseed while locked.
          pred <= prbs_step(pred);
          if (hit_c) begin
            miss_cnt <= '0;
          end else begin
            err_pulse <= 1'b1;
            if (miss_cnt + MISS_W'(1) >= MISS_W'(LOSS_CNT)) begin
              state     <= HUNT;
              locked    <= 1'b0;
              lost_lock <= 1'b1;
              miss_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + MISS_W'(1);
            end
          end
        end else if ((state == VERIFY) && hit_c) begin
          pred <= prbs_step(pred);
          if (match_cnt + MATCH_W'(1) >= MATCH_W'(LOCK_CNT)) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            match_cnt <= '0;
            miss_cnt  <= '0;
          end else begin
            match_cnt <= match_cnt + MATCH_W'(1);
          end
        end else if (data_in != '0) begin
          // Reseed from the received word; it counts as the first match.
          pred      <= prbs_step(data_in);
          state     <= SEED_LOCKS ? LOCKED : VERIFY;
          locked    <= SEED_LOCKS;
          match_cnt <= SEED_LOCKS ? '0 : MATCH_W'(1);
          miss_cnt  <= '0;
        end else begin
          state     <= HUNT;
          match_cnt <= '0;
        end
      end
    end
  end

  sat_counter #(.W(32)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc_c),
    .clear (clear),
    .count (err_count)
  );

  sat_counter #(.W(32)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (word_inc_c),
    .clear (clear),
    .count (word_count)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Randomized self-checking bench for prbs_checker against a behavioural model.
module tb_prbs_checker;

  localparam int unsigned LOCK_N = 4;
  localparam int unsigned LOSS_N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse, lost_lock;
  logic [31:0] err_count, word_count;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int          m_mode;   // 0 hunting, 1 verifying, 2 locked
  logic [31:0] m_p;
  int          m_match, m_miss;
  logic        m_err, m_lost;
  logic [31:0] m_ec, m_wc;
  logic [31:0] g_p;      // transmitter PRBS state

  prbs_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .lost_lock  (lost_lock),
    .err_count  (err_count),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] nxt(input logic [31:0] x);
    int ones;
    ones = $countones(x & 32'hEA00_0001);
    return (x << 1) | 32'(ones % 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_p = '0; m_match = 0; m_miss = 0;
    m_err = 1'b0; m_lost = 1'b0; m_ec = '0; m_wc = '0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic clr);
    m_err = 1'b0;
    m_lost = 1'b0;
    if (v) begin
      if (m_mode == 2) begin
        if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
        if (d != m_p) begin
          m_err = 1'b1;
          if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
          m_miss++;
          if (m_miss == LOSS_N) begin
            m_mode = 0; m_lost = 1'b1; m_miss = 0; m_match = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_p = nxt(m_p);
      end else if (m_mode == 1 && d == m_p) begin
        m_p = nxt(m_p);
        m_match++;
        if (m_match == LOCK_N) begin
          m_mode = 2; m_match = 0; m_miss = 0;
        end
      end else if (d != 0) begin
        m_p = nxt(d); m_match = 1; m_mode = 1;
      end else begin
        m_mode = 0; m_match = 0;
      end
    end
    if (clr) begin
      m_ec = '0; m_wc = '0;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".locked"},     32'(locked),    32'(m_mode == 2));
    check({ph, ".err_pulse"},  32'(err_pulse), 32'(m_err));
    check({ph, ".lost_lock"},  32'(lost_lock), 32'(m_lost));
    check({ph, ".err_count"},  err_count,      m_ec);
    check({ph, ".word_count"}, word_count,     m_wc);
  endtask

  // Apply one cycle of input, advance the model, sample 1 time unit after the edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic clr, input string ph);
    data_valid = v; data_in = d; clear = clr;
    @(posedge clk);
    #1;
    model_step(v, d, clr);
    check_all(ph);
  endtask

  // Send the next transmitter word, optionally corrupted.
  task automatic send(input logic v, input logic [31:0] flip, input logic clr, input string ph);
    logic [31:0] w;
    w = g_p ^ flip;
    if (v) g_p = nxt(g_p);
    drive(v, w, clr, ph);
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({ph, ".in_rst"});
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset("por");

    // Zero words while hunting are ignored.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h0, 1'b0, "zero_hunt");
    check("zero_hunt.locked_const", 32'(locked), 32'd0);

    // Acquire from seed 1: lock rises after the 4th word.
    g_p = 32'h0000_0001;
    check("seed_seq", nxt(nxt(32'h1)), 32'h0000_0007);
    for (int i = 0; i < 3; i++) send(1'b1, '0, 1'b0, "acquire");
    check("acquire.not_yet", 32'(locked), 32'd0);
    send(1'b1, '0, 1'b0, "acquire");
    check("acquire.lock_rise", 32'(locked), 32'd1);
    check("acquire.err0", err_count, 32'd0);

    // Single-bit error while locked.
    for (int i = 0; i < 3; i++) send(1'b1, '0, 1'b0, "locked_clean");
    send(1'b1, 32'h1, 1'b0, "single_err");
    check("single_err.pulse", 32'(err_pulse), 32'd1);
    check("single_err.count", err_count, 32'd1);
    check("single_err.still_locked", 32'(locked), 32'd1);
    send(1'b1, '0, 1'b0, "after_err");
    check("after_err.no_pulse", 32'(err_pulse), 32'd0);

    // Clear collides with a mismatch: clear wins, pulse still fires.
    send(1'b1, 32'h8000_0000, 1'b1, "clear_vs_err");
    check("clear_vs_err.count", err_count, 32'd0);
    check("clear_vs_err.pulse", 32'(err_pulse), 32'd1);
    send(1'b1, '0, 1'b0, "clear_vs_err.clean");

    // Loss of lock after LOSS_N consecutive errors, then relock.
    for (int i = 0; i < LOSS_N; i++) send(1'b1, 32'h0000_0100, 1'b0, "loss");
    check("loss.lost_pulse", 32'(lost_lock), 32'd1);
    check("loss.locked", 32'(locked), 32'd0);
    check("loss.err_count", err_count, 32'd8);
    for (int i = 0; i < LOCK_N; i++) send(1'b1, '0, 1'b0, "relock");
    check("relock.locked", 32'(locked), 32'd1);

    // Reset while locked with valid gaps: immediate drop, no lost_lock pulse.
    for (int i = 0; i < 6; i++) send(1'(i % 2), '0, 1'b0, "gaps");
    do_reset("mid_rst");
    check("mid_rst.no_lost", 32'(lost_lock), 32'd0);
    for (int i = 0; i < 2 * LOCK_N; i++) send(1'(i % 2), '0, 1'b0, "relock_gaps");
    check("relock_gaps.locked", 32'(locked), 32'd1);

    // Randomized traffic: gaps, bursts of errors, zero words, clears and resets.
    for (int i = 0; i < 4000; i++) begin
      logic        v, clr;
      logic [31:0] flip;
      int          r;
      r    = int'($urandom_range(0, 999));
      v    = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      flip = '0;
      if (r < 2) begin
        do_reset("rand_rst");
      end else if (r < 12) begin
        drive(v, 32'h0, clr, "rand_zero");
      end else begin
        if (r < 80) flip = $urandom() | 32'h1;
        if (r >= 80 && r < 100) begin
          for (int k = 0; k < int'($urandom_range(6, 10)); k++)
            send(1'b1, 32'h0000_0040, 1'b0, "rand_burst");
        end
        send(v, flip, clr, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, consecutive matches needed to declare lock.
REQ-002 SHALL have parameter LOSS_CNT, default 8, consecutive mismatches in LOCKED that drop lock.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_in  input  32  received PRBS word.
REQ-006 SHALL have port data_valid  input  1  data_in qualifier; one word per asserted cycle.
REQ-007 SHALL have port clear  input  1  synchronous clear of err_count and word_count.
REQ-008 SHALL have port locked  output  1  high while in LOCKED.
REQ-009 SHALL have port err_pulse  output  1  one-cycle pulse per mismatching word in LOCKED.
REQ-010 SHALL have port lost_lock  output  1  one-cycle pulse on LOCKED->HUNT.
REQ-011 SHALL have port err_count  output  32  saturating count of mismatching words in LOCKED.
REQ-012 SHALL have port word_count  output  32  saturating count of valid words checked in LOCKED.

Function
REQ-013 SHALL hold a 32-bit predictor P; step(P) = {P[30:0], P[31]^P[30]^P[29]^P[27]^P[25]^P[0]}.
REQ-014 SHALL implement states HUNT, VERIFY, LOCKED; cycles with data_valid=0 change no state, counter or predictor.
REQ-015 HUNT: valid nonzero word -> P=step(data_in), match counter=1, go VERIFY; valid zero word ignored, stay HUNT.
REQ-016 VERIFY: valid word equal to P -> P=step(P), match counter +1; when count reaches LOCK_CNT go LOCKED.
REQ-017 VERIFY: valid word not equal to P -> behave as HUNT for that word (reseed from data_in or stay HUNT if zero).
REQ-018 LOCKED: every valid word -> P=step(P) regardless of match (free-running prediction, no reseed).
REQ-019 LOCKED mismatch -> err_pulse next cycle, err_count +1, consecutive-miss counter +1; match resets miss counter to 0.
REQ-020 LOCKED: miss counter reaching LOSS_CNT -> go HUNT, lost_lock pulse next cycle, miss and match counters cleared.
REQ-021 err_count, word_count SHALL saturate at 0xFFFFFFFF; no wrap.
REQ-022 clear SHALL zero both counters and take priority over a same-cycle increment; lock state, P and miss counter unaffected.
REQ-023 locked SHALL be registered: rises the cycle after the LOCK_CNT-th consecutive match, falls together with lost_lock.
REQ-024 err_pulse and lost_lock SHALL be registered, latency one cycle from the causing valid word.
REQ-025 counters SHALL be visible updated one cycle after the causing word.

Reset
REQ-026 rst SHALL force state HUNT, P=0, match/miss counters 0, locked=0, err_pulse=0, lost_lock=0, err_count=0, word_count=0.
REQ-027 rst asserted mid-operation SHALL abort lock immediately with no lost_lock pulse; re-acquisition restarts from HUNT.

Structure
REQ-028 shared package prbs_pkg SHALL hold state enum, tap mask constant 0xEA000001, and the step function.
REQ-029 one sub-module sat_counter (32-bit, inc, clear, saturating) SHALL be instantiated twice for err_count and word_count.

Verification
REQ-030 after rst, words from seed 0x00000001 (0x00000001, 0x00000003, 0x00000007, ...) valid each cycle -> locked rises after 4th match, err_count=0.
REQ-031 locked, one word XOR 0x00000001 -> one err_pulse, err_count=1, locked stays 1, next correct word matches.
REQ-032 locked, 8 consecutive corrupted words -> err_count=8, lost_lock pulse, locked=0, state HUNT; clean stream relocks.
REQ-033 all-zero words in HUNT -> stays HUNT, locked=0, no counters change.
REQ-034 clear asserted same cycle as a mismatching valid word -> err_count=0 after, err_pulse still asserted.
REQ-035 rst pulsed while locked with data_valid gaps -> all outputs 0 immediately, no lost_lock, relock after 4 matches.
